// File: rtl/sram_arbiter.sv
// sram_arbiter: shares the single ram_ctrl read/write/workdone port between
// the VGA frame reader, the camera frame writer and a general-purpose port.
// One access at a time walks IDLE -> ISSUE -> WAIT -> DONE. VGA has priority,
// with a burst limit so cam/gen cannot starve. cam and gen share a
// round-robin pointer. Every access is bounded by a WAIT-cycle timeout.
module sram_arbiter #(
    parameter int VGA_BURST = 4,    // max consecutive VGA grants while others wait (<= 255)
    parameter int TIMEOUT   = 255   // max WAIT cycles before abort, 1..255
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        vga_req,
    input  logic [19:0] vga_addr,
    output logic        vga_ack,
    output logic [31:0] vga_rdata,

    input  logic        cam_req,
    input  logic [19:0] cam_addr,
    input  logic [31:0] cam_wdata,
    output logic        cam_ack,

    input  logic        gen_req,
    input  logic        gen_we,
    input  logic [19:0] gen_addr,
    input  logic [31:0] gen_wdata,
    output logic        gen_ack,
    output logic [31:0] gen_rdata,

    output logic        mem_read,
    output logic        mem_write,
    output logic [19:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_done,
    input  logic [31:0] mem_rdata,

    output logic        busy,
    output logic [1:0]  grant,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] G_NONE = 2'd0;
    localparam logic [1:0] G_VGA  = 2'd1;
    localparam logic [1:0] G_CAM  = 2'd2;
    localparam logic [1:0] G_GEN  = 2'd3;

    state_t      r_state;
    state_t      w_next;

    logic [1:0]  r_grant;      // owner of the access in flight
    logic        r_we;         // direction of the access in flight
    logic [19:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_vga_rdata;
    logic [31:0] r_gen_rdata;
    logic [7:0]  r_streak;     // VGA grants in a row while cam/gen were waiting
    logic        r_rr_gen;     // 0: cam favoured on a cam/gen tie, 1: gen favoured
    logic [7:0]  r_cnt;        // WAIT cycles elapsed, 1 in the first WAIT cycle
    logic        r_tmo_err;

    logic        w_others;
    logic        w_vga_mask;
    logic [1:0]  w_win;
    logic        w_done_ok;
    logic        w_tmo;

    // Arbitration: who would win if the block were IDLE this cycle.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no latch is inferred.
        w_win      = G_NONE;
        w_others   = cam_req | gen_req;
        w_vga_mask = (r_streak == 8'(VGA_BURST)) && w_others;
        if (vga_req && !w_vga_mask) begin
            w_win = G_VGA;
        end else if (cam_req && gen_req) begin
            w_win = r_rr_gen ? G_GEN : G_CAM;
        end else if (cam_req) begin
            w_win = G_CAM;
        end else if (gen_req) begin
            w_win = G_GEN;
        end
    end

    // mem_done is only meaningful in WAIT; it beats a timeout on the same cycle.
    assign w_done_ok = (r_state == S_WAIT) && mem_done;
    assign w_tmo     = (r_state == S_WAIT) && !mem_done && (r_cnt == 8'(TIMEOUT));

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_win != G_NONE) w_next = S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  if (w_done_ok || w_tmo) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Access latch, starvation/round-robin bookkeeping, WAIT counter and read capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant     <= G_NONE;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_vga_rdata <= '0;
            r_gen_rdata <= '0;
            r_streak    <= '0;
            r_rr_gen    <= 1'b0;
            r_cnt       <= '0;
            r_tmo_err   <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_win != G_NONE) begin
                        r_grant <= w_win;
                    end
                    unique case (w_win)
                        G_VGA: begin
                            r_we    <= 1'b0;
                            r_addr  <= vga_addr;
                            r_wdata <= '0;
                            if (w_others) r_streak <= r_streak + 8'd1;
                        end
                        G_CAM: begin
                            r_we     <= 1'b1;
                            r_addr   <= cam_addr;
                            r_wdata  <= cam_wdata;
                            r_streak <= '0;
                            r_rr_gen <= 1'b1;
                        end
                        G_GEN: begin
                            r_we     <= gen_we;
                            r_addr   <= gen_addr;
                            r_wdata  <= gen_wdata;
                            r_streak <= '0;
                            r_rr_gen <= 1'b0;
                        end
                        default: ;
                    endcase
                end
                S_ISSUE: r_cnt <= 8'd1;
                S_WAIT: begin
                    r_cnt <= r_cnt + 8'd1;
                    if (w_done_ok) begin
                        if (r_grant == G_VGA)          r_vga_rdata <= mem_rdata;
                        if (r_grant == G_GEN && !r_we) r_gen_rdata <= mem_rdata;
                    end else if (w_tmo) begin
                        r_tmo_err <= 1'b1;
                        if (r_grant == G_VGA)          r_vga_rdata <= '0;
                        if (r_grant == G_GEN && !r_we) r_gen_rdata <= '0;
                    end
                end
                S_DONE: r_grant <= G_NONE;
                default: ;
            endcase
        end
    end

    // Strobes and acks decode straight from registered state.
    assign mem_read    = ((r_state == S_ISSUE) || (r_state == S_WAIT)) && !r_we;
    assign mem_write   = ((r_state == S_ISSUE) || (r_state == S_WAIT)) &&  r_we;
    assign mem_addr    = r_addr;
    assign mem_wdata   = r_wdata;
    assign vga_ack     = (r_state == S_DONE) && (r_grant == G_VGA);
    assign cam_ack     = (r_state == S_DONE) && (r_grant == G_CAM);
    assign gen_ack     = (r_state == S_DONE) && (r_grant == G_GEN);
    assign vga_rdata   = r_vga_rdata;
    assign gen_rdata   = r_gen_rdata;
    assign busy        = (r_state != S_IDLE);
    assign grant       = r_grant;
    assign timeout_err = r_tmo_err;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: single read latency, cam/gen round robin,
// VGA burst limit, timeout abort, reset mid-access, done-vs-timeout tie.
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        vga_req, cam_req, gen_req, gen_we;
    logic [19:0] vga_addr, cam_addr, gen_addr;
    logic [31:0] cam_wdata, gen_wdata;
    logic        vga_ack, cam_ack, gen_ack;
    logic [31:0] vga_rdata, gen_rdata;
    logic        mem_read, mem_write, mem_done;
    logic [19:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        busy, timeout_err;
    logic [1:0]  grant;

    int n_tests = 0;
    int n_fail  = 0;

    sram_arbiter #(.VGA_BURST(4), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_ack(vga_ack), .vga_rdata(vga_rdata),
        .cam_req(cam_req), .cam_addr(cam_addr), .cam_wdata(cam_wdata), .cam_ack(cam_ack),
        .gen_req(gen_req), .gen_we(gen_we), .gen_addr(gen_addr), .gen_wdata(gen_wdata),
        .gen_ack(gen_ack), .gen_rdata(gen_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_done(mem_done), .mem_rdata(mem_rdata),
        .busy(busy), .grant(grant), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Starts from IDLE with requests already driven; returns in the DONE cycle.
    // mem_done is raised so it is seen k cycles after the strobe first rises.
    task automatic run_access(input int k, input logic [31:0] rdata,
                              output logic [1:0] g, output logic [19:0] a,
                              output logic [31:0] wd, output logic wr, output logic rd,
                              output int nstrobe, output int early_ack,
                              output logic [2:0] acks, output logic strobe_done);
        nstrobe   = 0;
        early_ack = 0;
        mem_rdata = rdata;
        tick();
        g = grant; a = mem_addr; wd = mem_wdata; wr = mem_write; rd = mem_read;
        if (mem_read || mem_write) nstrobe++;
        if (vga_ack || cam_ack || gen_ack) early_ack++;
        for (int i = 1; i <= k; i++) begin
            tick();
            if (mem_read || mem_write) nstrobe++;
            if (vga_ack || cam_ack || gen_ack) early_ack++;
            if (i == k) mem_done = 1'b1;
        end
        tick();
        mem_done    = 1'b0;
        acks        = {vga_ack, cam_ack, gen_ack};
        strobe_done = mem_read | mem_write;
    endtask

    function automatic logic [2:0] ack_of(input logic [1:0] g);
        case (g)
            2'd1:    return 3'b100;
            2'd2:    return 3'b010;
            2'd3:    return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [1:0]  g;
        logic [19:0] a;
        logic [31:0] wd;
        logic        wr, rd, sd;
        logic [2:0]  acks;
        int          ns, ea;
        logic [1:0]  exp_g2 [4]  = '{2'd2, 2'd3, 2'd2, 2'd3};
        logic [1:0]  exp_g3 [10] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2,
                                     2'd1, 2'd1, 2'd1, 2'd1, 2'd3};

        rst = 1'b1;
        vga_req = 0; cam_req = 0; gen_req = 0; gen_we = 0;
        vga_addr = '0; cam_addr = '0; gen_addr = '0;
        cam_wdata = '0; gen_wdata = '0;
        mem_done = 0; mem_rdata = '0;
        tick();
        tick();

        // Reset state
        chk("rst_grant", 32'(grant), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_strobes", 32'({mem_read, mem_write}), 0);
        chk("rst_acks", 32'({vga_ack, cam_ack, gen_ack}), 0);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_rdata", vga_rdata | gen_rdata, 0);
        chk("rst_tmo", 32'(timeout_err), 0);
        rst = 1'b0;
        tick();

        // Single VGA read, done 3 cycles after strobe
        vga_req = 1; vga_addr = 20'h00010;
        run_access(3, 32'h12345678, g, a, wd, wr, rd, ns, ea, acks, sd);
        chk("v1_grant", 32'(g), 1);
        chk("v1_addr", 32'(a), 32'h10);
        chk("v1_read", 32'({rd, wr}), 32'b10);
        chk("v1_strobe_cycles", ns, 4);
        chk("v1_early_ack", ea, 0);
        chk("v1_ack", 32'(acks), 32'b100);
        chk("v1_strobe_done", 32'(sd), 0);
        chk("v1_rdata", vga_rdata, 32'h12345678);
        vga_req = 0;
        tick();
        chk("v1_idle", 32'({busy, grant, vga_ack}), 0);
        chk("v1_rdata_hold", vga_rdata, 32'h12345678);

        // cam and gen writes held together: round robin
        cam_req = 1; cam_addr = 20'h00100; cam_wdata = 32'hCAFE0001;
        gen_req = 1; gen_we = 1; gen_addr = 20'h00200; gen_wdata = 32'h6E6E0002;
        for (int i = 0; i < 4; i++) begin
            run_access(1, 32'hFFFF0000, g, a, wd, wr, rd, ns, ea, acks, sd);
            chk($sformatf("rr_grant%0d", i), 32'(g), 32'(exp_g2[i]));
            chk($sformatf("rr_addr%0d", i), 32'(a), exp_g2[i] == 2'd2 ? 32'h100 : 32'h200);
            chk($sformatf("rr_wdata%0d", i), wd, exp_g2[i] == 2'd2 ? 32'hCAFE0001 : 32'h6E6E0002);
            chk($sformatf("rr_write%0d", i), 32'(wr), 1);
            chk($sformatf("rr_ack%0d", i), 32'(acks), 32'(ack_of(exp_g2[i])));
            tick();
        end
        chk("rr_gen_rdata_untouched", gen_rdata, 0);

        // VGA + cam + gen held: burst limit then fall back to round robin
        vga_req = 1;
        for (int i = 0; i < 10; i++) begin
            run_access(1, 32'h3000_0000 + 32'(i), g, a, wd, wr, rd, ns, ea, acks, sd);
            chk($sformatf("burst_grant%0d", i), 32'(g), 32'(exp_g3[i]));
            chk($sformatf("burst_ack%0d", i), 32'(acks), 32'(ack_of(exp_g3[i])));
            if (i == 9) begin
                vga_req = 0; cam_req = 0; gen_req = 0;
            end
            tick();
        end
        chk("burst_vga_rdata", vga_rdata, 32'h3000_0008);

        // gen read sets gen_rdata to something non-zero
        gen_req = 1; gen_we = 0; gen_addr = 20'h00ABC;
        run_access(2, 32'hA5A50001, g, a, wd, wr, rd, ns, ea, acks, sd);
        chk("gr_ack", 32'(acks), 32'b001);
        chk("gr_rdata", gen_rdata, 32'hA5A50001);
        chk("gr_tmo_clear", 32'(timeout_err), 0);
        gen_req = 0;
        tick();

        // Timeout: mem_done never arrives, TIMEOUT=8
        gen_req = 1; gen_we = 0; gen_addr = 20'h00333; mem_rdata = 32'hDEADBEEF;
        tick();
        ns = mem_read ? 1 : 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (mem_read) ns++;
            else break;
        end
        chk("to_strobe_cycles", ns, 9);
        chk("to_ack", 32'({vga_ack, cam_ack, gen_ack}), 32'b001);
        chk("to_rdata", gen_rdata, 0);
        chk("to_err", 32'(timeout_err), 1);
        gen_req = 0;
        tick();
        chk("to_err_held", 32'(timeout_err), 1);
        chk("to_idle", 32'(busy), 0);

        // Next access after a timeout completes normally
        vga_req = 1;
        run_access(1, 32'h0BADF00D, g, a, wd, wr, rd, ns, ea, acks, sd);
        chk("post_to_ack", 32'(acks), 32'b100);
        chk("post_to_rdata", vga_rdata, 32'h0BADF00D);
        chk("post_to_err", 32'(timeout_err), 1);
        vga_req = 0;
        tick();

        // mem_done while IDLE is ignored
        mem_done = 1;
        tick();
        mem_done = 0;
        chk("stray_done", 32'({busy, vga_ack, cam_ack, gen_ack}), 0);

        // Reset during WAIT
        cam_req = 1; cam_addr = 20'h00400; cam_wdata = 32'h11112222;
        tick();
        chk("rw_issue", 32'(mem_write), 1);
        tick();
        rst = 1; cam_req = 0;
        tick();
        chk("rw_strobes", 32'({mem_read, mem_write}), 0);
        chk("rw_grant_busy", 32'({grant, busy}), 0);
        chk("rw_acks", 32'({vga_ack, cam_ack, gen_ack}), 0);
        chk("rw_addr_data", 32'(mem_addr) | mem_wdata, 0);
        chk("rw_regs", 32'(timeout_err) | vga_rdata | gen_rdata, 0);
        rst = 0;
        tick();
        chk("rw_no_ack", 32'({cam_ack, busy}), 0);

        // mem_done on the same cycle the timeout limit is reached
        gen_req = 1; gen_we = 0; gen_addr = 20'h00555;
        run_access(8, 32'h77778888, g, a, wd, wr, rd, ns, ea, acks, sd);
        chk("tie_strobe_cycles", ns, 9);
        chk("tie_ack", 32'(acks), 32'b001);
        chk("tie_rdata", gen_rdata, 32'h77778888);
        chk("tie_err", 32'(timeout_err), 0);
        gen_req = 0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
